// File: rtl/ext_pipe.sv
// ---------------------------------------------------------------------------
// ext_pipe : two-stage pipelined immediate / data extender
//
// Takes an immediate and a 3-bit extension opcode over a valid/ready
// handshake. The request is captured in S1, extended on the way to S2,
// and presented from S2 registers two cycles after acceptance.
// Streams at one result per cycle, supports backpressure and a
// synchronous flush that drops everything in flight.
//
// Optional feature macro: EXT_ILLEGAL_TRAP_EN
//   defined   : EOp 110/111 give ext = 0 and raise out_illegal
//   undefined : out_illegal port is absent, EOp 110/111 sign-extend
//
// Parameters
//   IMM_W    immediate width (>= 8)
//   DATA_W   result width (>= IMM_W+2)
//   SHIFT_BR left shift for branch-offset mode (< DATA_W-IMM_W+1)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset (has priority over flush)
//   flush       synchronous pipeline clear, same-cycle input discarded
//   in_valid    request valid
//   in_ready    block can accept this cycle
//   imm         immediate / data to extend
//   EOp         extension opcode
//   out_valid   result valid
//   out_ready   consumer accepts result
//   ext         extended result (registered)
//   out_illegal result came from a reserved EOp (macro builds only)
// ---------------------------------------------------------------------------
module ext_pipe #(
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  parameter int SHIFT_BR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        EOp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext
`ifdef EXT_ILLEGAL_TRAP_EN
  ,
  output logic              out_illegal
`endif
);

  localparam logic [2:0] OpSext   = 3'b000;
  localparam logic [2:0] OpZext   = 3'b001;
  localparam logic [2:0] OpUpper  = 3'b010;
  localparam logic [2:0] OpBranch = 3'b011;
  localparam logic [2:0] OpSextB  = 3'b100;
  localparam logic [2:0] OpZextB  = 3'b101;
`ifdef EXT_ILLEGAL_TRAP_EN
  localparam logic [2:0] OpRsvd0  = 3'b110;
  localparam logic [2:0] OpRsvd1  = 3'b111;
`endif

  logic              v1_q, v1_d;
  logic [IMM_W-1:0]  imm1_q, imm1_d;
  logic [2:0]        eop1_q, eop1_d;
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] ext_q, ext_d;
`ifdef EXT_ILLEGAL_TRAP_EN
  logic              ill_q, ill_d;
  logic              illNext;
`endif

  logic              s2Ready;
  logic [DATA_W-1:0] sextImm, zextImm, upperImm, branchImm;
  logic [DATA_W-1:0] sextByte, zextByte, extNext;

  // Backpressure chain: S2 frees up when empty or being drained, and S1
  // can take a new request when empty or when it can move into S2.
  // Ready is held low while reset is asserted.
  always_comb begin
    s2Ready  = !v2_q || out_ready;
    in_ready = !reset && (!v1_q || s2Ready);
  end

  // Extension datapath from the S1 registers. Every mode is formed in
  // parallel and the opcode picks one; reserved opcodes fall through to
  // sign-extension unless the illegal trap is built in.
  always_comb begin
    sextImm   = {{(DATA_W-IMM_W){imm1_q[IMM_W-1]}}, imm1_q};
    zextImm   = {{(DATA_W-IMM_W){1'b0}}, imm1_q};
    upperImm  = {imm1_q, {(DATA_W-IMM_W){1'b0}}};
    branchImm = sextImm << SHIFT_BR;
    sextByte  = {{(DATA_W-8){imm1_q[7]}}, imm1_q[7:0]};
    zextByte  = {{(DATA_W-8){1'b0}}, imm1_q[7:0]};
    extNext   = sextImm;
`ifdef EXT_ILLEGAL_TRAP_EN
    illNext   = 1'b0;
`endif
    case (eop1_q)
      OpSext:   extNext = sextImm;
      OpZext:   extNext = zextImm;
      OpUpper:  extNext = upperImm;
      OpBranch: extNext = branchImm;
      OpSextB:  extNext = sextByte;
      OpZextB:  extNext = zextByte;
`ifdef EXT_ILLEGAL_TRAP_EN
      OpRsvd0, OpRsvd1: begin
        extNext = '0;
        illNext = 1'b1;
      end
`endif
      default:  extNext = sextImm;
    endcase
  end

  // Next-state for both stages. S2 reloads whenever it is free, taking
  // S1's valid (which may be a bubble); its data only changes on a real
  // item so a bubble never disturbs ext. S1 loads whenever in_ready.
  // Flush clears both valids and wins over any same-cycle acceptance.
  always_comb begin
    v1_d   = v1_q;
    imm1_d = imm1_q;
    eop1_d = eop1_q;
    v2_d   = v2_q;
    ext_d  = ext_q;
`ifdef EXT_ILLEGAL_TRAP_EN
    ill_d  = ill_q;
`endif
    if (s2Ready) begin
      v2_d = v1_q;
      if (v1_q) begin
        ext_d = extNext;
`ifdef EXT_ILLEGAL_TRAP_EN
        ill_d = illNext;
`endif
      end
    end
    if (in_ready) begin
      v1_d = in_valid;
      if (in_valid) begin
        imm1_d = imm;
        eop1_d = EOp;
      end
    end
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset clearing valids and the
  // visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      imm1_q <= '0;
      eop1_q <= '0;
      v2_q   <= 1'b0;
      ext_q  <= '0;
`ifdef EXT_ILLEGAL_TRAP_EN
      ill_q  <= 1'b0;
`endif
    end else begin
      v1_q   <= v1_d;
      imm1_q <= imm1_d;
      eop1_q <= eop1_d;
      v2_q   <= v2_d;
      ext_q  <= ext_d;
`ifdef EXT_ILLEGAL_TRAP_EN
      ill_q  <= ill_d;
`endif
    end
  end

  // Outputs come straight from the S2 registers.
  always_comb begin
    out_valid = v2_q;
    ext       = ext_q;
`ifdef EXT_ILLEGAL_TRAP_EN
    out_illegal = ill_q;
`endif
  end

endmodule

// File: tb/tb_ext_pipe.sv
// ---------------------------------------------------------------------------
// tb_ext_pipe : self-checking bench for ext_pipe (default parameters)
//
// Inputs are driven just after the falling edge and the handshake is
// evaluated one time unit before the rising edge. Accepted requests
// push their modelled result into a scoreboard queue; every emitted
// result pops and compares. Reset and flush empty the queue.
// ---------------------------------------------------------------------------
module tb_ext_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  EOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext;
`ifdef EXT_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  typedef struct {
    logic [31:0] ext;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  bit   chkLat      = 0;
  bit   accepted    = 0;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT_BR(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .EOp       (EOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ext       (ext)
`ifdef EXT_ILLEGAL_TRAP_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of the extender for 16-bit immediates, 32-bit result.
  function automatic exp_t model(input logic [15:0] i, input logic [2:0] op,
                                 input int c);
    exp_t        e;
    logic [31:0] s;
    s     = 32'($signed(i));
    e.ill = 1'b0;
    e.cyc = c;
    case (op)
      3'd0: e.ext = s;
      3'd1: e.ext = {16'h0000, i};
      3'd2: e.ext = {i, 16'h0000};
      3'd3: e.ext = s << 2;
      3'd4: e.ext = 32'($signed(i[7:0]));
      3'd5: e.ext = {24'h000000, i[7:0]};
      default: begin
`ifdef EXT_ILLEGAL_TRAP_EN
        e.ext = 32'h0;
        e.ill = 1'b1;
`else
        e.ext = s;
`endif
      end
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs after the falling edge, then evaluate
  // both handshakes against the scoreboard just before the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] i,
                               input logic [2:0] op, input logic ordy,
                               input logic fl, input logic rst);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    imm       = i;
    EOp       = op;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #4;
    accepted = 0;
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("ext", ext, e.ext);
`ifdef EXT_ILLEGAL_TRAP_EN
          checkOutput("out_illegal", 32'(out_illegal), 32'(e.ill));
`endif
          if (chkLat) checkOutput("latency", 32'(cycle - e.cyc), 32'd2);
        end
      end else if (out_valid && sb.size() != 0) begin
        checkOutput("stall_ext", ext, sb[0].ext);
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(imm, EOp, cycle));
        accepted = 1;
      end
    end
    cycle++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0, 3'd0, ordy, 1'b0, 1'b0);
  endtask

  logic [15:0] items [5];
  int          idx;
  int          c;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; imm = '0; EOp = '0; out_ready = 1'b0;

    // Reset: ready low while held, clean state afterwards
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ext", ext, 32'd0);
    checkOutput("rst_in_ready_high", 32'(in_ready), 32'd1);

    // Back-to-back modes on 0x8001, full rate, latency 2
    chkLat = 1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'h8001, 3'(k), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1280, 3'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1280, 3'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7F7F, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 3'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00F0, 3'd7, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    checkOutput("directed_drain", 32'(sb.size()), 32'd0);

    // Stall: out_ready low for cycles 3..6 of a 5-item stream
    chkLat = 0;
    items[0] = 16'h1111; items[1] = 16'h8222; items[2] = 16'h0333;
    items[3] = 16'hF444; items[4] = 16'h0555;
    idx = 0;
    c   = 1;
    while (!(idx == 5 && sb.size() == 0) && c <= 40) begin
      applyStimulus(idx < 5, (idx < 5) ? items[idx] : 16'h0, 3'(idx % 4),
                    !(c >= 3 && c <= 6), 1'b0, 1'b0);
      if (c == 4) checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      if (c == 5) checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      if (accepted) idx++;
      c++;
    end
    checkOutput("stall_all_accepted", 32'(idx), 32'd5);
    checkOutput("stall_drain", 32'(sb.size()), 32'd0);
    idle(2, 1'b1);

    // Flush with two items in flight and a same-cycle input
    chkLat = 1;
    applyStimulus(1'b1, 16'hAAAA, 3'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 3'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hCCCC, 3'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0DDD, 3'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    idle(5, 1'b1);
    checkOutput("flush_drain", 32'(sb.size()), 32'd0);

    // Reset while stalled with a result pending
    chkLat = 0;
    applyStimulus(1'b1, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5678, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("prerst_out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("postrst_ext", ext, 32'd0);
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    idle(6, 1'b1);
    checkOutput("random_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
